// File: rtl/hamming_tx_scheduler.sv
// Round-robin serializer sharing one line between two Hamming(7,4) codeword channels.
// Optional TX_CHAN_ID_EN prefixes each frame with the granted channel-ID bit.
module hamming_tx_scheduler #(
  parameter int unsigned CW_WIDTH   = 7,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  input  logic [CW_WIDTH-1:0] req0_data_i,
  output logic                req0_ready_o,
  input  logic                req1_valid_i,
  input  logic [CW_WIDTH-1:0] req1_data_i,
  output logic                req1_ready_o,
  output logic                ser_out_o,
  output logic                ser_frame_o,
  output logic                ser_sof_o,
  output logic                busy_o,
  output logic                grant_id_o
);

`ifdef TX_CHAN_ID_EN
  localparam int unsigned FrameLen = CW_WIDTH + 1;
`else
  localparam int unsigned FrameLen = CW_WIDTH;
`endif
  localparam int unsigned CntW = $clog2(CW_WIDTH + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameLen);
  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e              state_q;
  logic [CW_WIDTH-1:0] shift_q;
  logic [CntW-1:0]     cnt_q;
  logic [3:0]          gap_q;
  logic                ser_out_q, frame_q, sof_q, busy_q, grant_id_q, last_q;

  logic                grant, take;
  logic [CW_WIDTH-1:0] data_sel;

  always_comb begin
    grant = req1_valid_i;
    if (req0_valid_i && req1_valid_i) grant = ~last_q;
  end

  assign req0_ready_o = (state_q == StIdle) && req0_valid_i && !grant;
  assign req1_ready_o = (state_q == StIdle) && req1_valid_i && grant;
  assign take         = req0_ready_o || req1_ready_o;
  assign data_sel     = grant ? req1_data_i : req0_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      ser_out_q  <= 1'b0;
      frame_q    <= 1'b0;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take) begin
            // shift_q holds the bits still to be driven, MSB first
`ifdef TX_CHAN_ID_EN
            shift_q   <= data_sel;
            ser_out_q <= grant;
`else
            shift_q   <= {data_sel[CW_WIDTH-2:0], 1'b0};
            ser_out_q <= data_sel[CW_WIDTH-1];
`endif
            frame_q    <= 1'b1;
            sof_q      <= 1'b1;
            grant_id_q <= grant;
            last_q     <= grant;
            cnt_q      <= CntW'(1);
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          sof_q <= 1'b0;
          if (cnt_q == CntLast) begin
            frame_q   <= 1'b0;
            ser_out_q <= 1'b0;
            cnt_q     <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
              gap_q   <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            ser_out_q <= shift_q[CW_WIDTH-1];
            shift_q   <= shift_q << 1;
            cnt_q     <= cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_out_o   = ser_out_q;
  assign ser_frame_o = frame_q;
  assign ser_sof_o   = sof_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Drives two schedulers (gap 0 and gap 3) from shared inputs and compares each
// against a frame-timeline reference model.
module tb_hamming_tx_scheduler;

  localparam int unsigned CW = 7;
  localparam int unsigned Gap0 = 0;
  localparam int unsigned Gap1 = 3;
`ifdef TX_CHAN_ID_EN
  localparam int FL = CW + 1;
`else
  localparam int FL = CW;
`endif

  logic          clk, rst, v0, v1;
  logic [CW-1:0] d0, d1;
  logic          rdy0 [2];
  logic          rdy1 [2];
  logic          so   [2];
  logic          sf   [2];
  logic          ss   [2];
  logic          bz   [2];
  logic          gid  [2];

  hamming_tx_scheduler #(.CW_WIDTH(CW), .GAP_CYCLES(Gap0)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(rdy0[0]),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(rdy1[0]),
    .ser_out_o(so[0]), .ser_frame_o(sf[0]), .ser_sof_o(ss[0]),
    .busy_o(bz[0]), .grant_id_o(gid[0])
  );

  hamming_tx_scheduler #(.CW_WIDTH(CW), .GAP_CYCLES(Gap1)) u_dut_g3 (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(rdy0[1]),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(rdy1[1]),
    .ser_out_o(so[1]), .ser_frame_o(sf[1]), .ser_sof_o(ss[1]),
    .busy_o(bz[1]), .grant_id_o(gid[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: either idle, or at position pos within a frame of FL bits followed by gap cycles.
  bit        idle_m  [2];
  int        pos_m   [2];
  logic [CW:0] bits_m [2];
  bit        grant_m [2];
  bit        last_m  [2];
  int        n_checks, n_fail;

  function automatic int gap_of(input int d);
    return (d == 0) ? int'(Gap0) : int'(Gap1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv0, input logic [CW-1:0] id0,
                      input logic iv1, input logic [CW-1:0] id1, input logic ir);
    logic e_out, e_frame, e_sof, e_busy, g, e_r0, e_r1;
    string pfx;
    @(negedge clk);
    rst = ir; v0 = iv0; d0 = id0; v1 = iv1; d1 = id1;
    #1;
    for (int d = 0; d < 2; d++) begin
      pfx = $sformatf("gap%0d", gap_of(d));
      if (idle_m[d]) begin
        e_out = 1'b0; e_frame = 1'b0; e_sof = 1'b0; e_busy = 1'b0;
      end else if (pos_m[d] < FL) begin
        e_out = bits_m[d][FL-1-pos_m[d]]; e_frame = 1'b1;
        e_sof = (pos_m[d] == 0); e_busy = 1'b1;
      end else begin
        e_out = 1'b0; e_frame = 1'b0; e_sof = 1'b0; e_busy = 1'b1;
      end
      g    = (iv0 && iv1) ? !last_m[d] : iv1;
      e_r0 = idle_m[d] && iv0 && !g;
      e_r1 = idle_m[d] && iv1 && g;
      check_eq({pfx, " ser_out"},   32'(so[d]),   32'(e_out));
      check_eq({pfx, " ser_frame"}, 32'(sf[d]),   32'(e_frame));
      check_eq({pfx, " ser_sof"},   32'(ss[d]),   32'(e_sof));
      check_eq({pfx, " busy"},      32'(bz[d]),   32'(e_busy));
      check_eq({pfx, " grant_id"},  32'(gid[d]),  32'(grant_m[d]));
      check_eq({pfx, " req0_ready"}, 32'(rdy0[d]), 32'(e_r0));
      check_eq({pfx, " req1_ready"}, 32'(rdy1[d]), 32'(e_r1));
      if (ir) begin
        idle_m[d] = 1'b1; pos_m[d] = 0; grant_m[d] = 1'b0; last_m[d] = 1'b1;
      end else if (idle_m[d]) begin
        if (e_r0 || e_r1) begin
          idle_m[d] = 1'b0; pos_m[d] = 0; grant_m[d] = g; last_m[d] = g;
`ifdef TX_CHAN_ID_EN
          bits_m[d] = {g, (g ? id1 : id0)};
`else
          bits_m[d] = {1'b0, (g ? id1 : id0)};
`endif
        end
      end else begin
        pos_m[d]++;
        if (pos_m[d] == FL + gap_of(d)) idle_m[d] = 1'b1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 2; d++) begin
      idle_m[d] = 1'b1; pos_m[d] = 0; bits_m[d] = '0; grant_m[d] = 1'b0; last_m[d] = 1'b1;
    end
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;

    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    idle_cycles(2);

    // single ch0 codeword
    step(1'b1, 7'b1011010, 1'b0, '0, 1'b0);
    idle_cycles(14);

    // both continuously valid: alternation
    for (int i = 0; i < 40; i++) step(1'b1, 7'h55, 1'b1, 7'h2A, 1'b0);
    idle_cycles(14);

    // ch1 raised mid-frame of ch0
    step(1'b1, 7'h33, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1, 7'h4C, 1'b0);
    idle_cycles(14);

    // reset pulse mid-frame, then both valid
    step(1'b1, 7'h6B, 1'b0, '0, 1'b0);
    idle_cycles(3);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 7'h0F, 1'b1, 7'h70, 1'b0);
    idle_cycles(14);

    // ch1 with distinctive pattern
    step(1'b0, '0, 1'b1, 7'b1110000, 1'b0);
    idle_cycles(14);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), CW'($urandom),
           1'($urandom_range(0, 3) != 0), CW'($urandom),
           1'($urandom_range(0, 99) == 0));
    end
    idle_cycles(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_tx_scheduler.md
Name: hamming_tx_scheduler

Overview:
- Shares one serial transmit line between two Hamming(7,4) encoder channels.
- Each channel presents a 7-bit codeword with a valid/ready handshake.
- A round-robin arbiter picks one channel, latches its codeword and shifts it out MSB first, one bit per clock, with frame-marker outputs.
- Sits between the encoder outputs and the line/decoder side, replacing free-running serialization with sequenced, handshaked framing.

Parameters:
- CW_WIDTH, 7: codeword width in bits; the frame length in bits.
- GAP_CYCLES, 0: extra idle cycles inserted after each frame, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  channel 0 codeword available.
- req0_data  in  CW_WIDTH  channel 0 codeword; bit CW_WIDTH-1 is sent first.
- req0_ready  out  1  channel 0 codeword accepted this cycle.
- req1_valid  in  1  channel 1 codeword available.
- req1_data  in  CW_WIDTH  channel 1 codeword.
- req1_ready  out  1  channel 1 codeword accepted this cycle.
- ser_out  out  1  serial data bit.
- ser_frame  out  1  high while ser_out carries a frame bit.
- ser_sof  out  1  high on the first bit of each frame.
- busy  out  1  high in SHIFT or GAP.
- grant_id  out  1  channel owning the current or most recent frame.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, ser_out=0, ser_frame=0, ser_sof=0, busy=0, grant_id=0, last_grant=1, bit counter=0, gap counter=0.
- Reset asserted mid-frame aborts the frame. On the next edge all outputs return to reset values and no partial bits follow.
- State machine, IDLE:
  - Arbitration is combinational.
  - Both valid: grant goes to the channel != last_grant.
  - Exactly one valid: grant goes to that channel.
  - reqX_ready = (state==IDLE) && reqX_valid && (grant==X). Never both high.
  - Transfer occurs when valid && ready.
  - On the transfer edge: shift_reg<=data, ser_out<=data[CW_WIDTH-1], ser_frame<=1, ser_sof<=1, grant_id<=X, last_grant<=X, bit counter<=1, busy<=1, state<=SHIFT.
  - No valid: outputs hold idle values (ser_out=0, ser_frame=0).
- State machine, SHIFT:
  - Each edge drives the next lower bit and sets ser_sof<=0.
  - After bit 0 has been driven for one cycle:
    - GAP_CYCLES>0: state<=GAP, ser_frame<=0, ser_out<=0.
    - Otherwise: state<=IDLE, ser_frame<=0, ser_out<=0, busy<=0.
- State machine, GAP: count GAP_CYCLES cycles with busy=1, then go to IDLE.
- Timing:
  - Acceptance-to-first-bit latency is 1 clock; the first bit is visible in the cycle after the ready/valid cycle.
  - ser_frame is high for exactly CW_WIDTH consecutive cycles per frame.
  - Minimum frame period is CW_WIDTH+1+GAP_CYCLES cycles; the IDLE arbitration cycle always occurs.
- Input rules:
  - reqX_data is sampled only on the transfer edge. Changes while not ready are ignored.
  - A valid that drops before being granted is never transmitted.
  - A valid asserted during SHIFT waits; no ready is given outside IDLE.
- Fairness: with both channels continuously valid, grants alternate 0,1,0,1… Starvation is impossible.
- Widths:
  - Bit counter is ceil(log2(CW_WIDTH+2)) bits and saturates only via its state transition.
  - Gap counter is 4 bits.

Optional Feature:
- Macro: TX_CHAN_ID_EN.
- When defined:
  - Each frame is prefixed with one channel-ID bit equal to the granted channel.
  - On the transfer edge ser_out<=X and ser_sof<=1; the CW_WIDTH codeword bits follow MSB first.
  - ser_frame is high for CW_WIDTH+1 cycles; minimum period is CW_WIDTH+2+GAP_CYCLES.
- When undefined: frames carry the codeword only, as above.

Test Plan:
- Reset, then req0_valid=1, req0_data=7'b1011010, req1 idle -> req0_ready high 1 cycle; next 7 cycles ser_out=1,0,1,1,0,1,0; ser_frame=1 and ser_sof=1 on the first only; grant_id=0; then one cycle ser_frame=0.
- Both valid continuously, req0_data=7'h55, req1_data=7'h2A, GAP_CYCLES=0 -> frames alternate ch0, ch1, ch0; 8-cycle period; first grant is ch0.
- req1_valid raised during a ch0 frame -> req1_ready stays 0 until IDLE; ch1 frame starts exactly 1 cycle after the ch0 frame ends.
- GAP_CYCLES=3, single channel always valid -> ser_frame low for 4 cycles between frames; busy low only in the IDLE cycle.
- rst pulsed for 1 cycle during bit 3 of a frame -> next cycle ser_out=0, ser_frame=0, busy=0; a subsequent both-valid request grants ch0.
- TX_CHAN_ID_EN defined, req1_data=7'b1110000 -> 8-bit frame 1,1,1,1,0,0,0,0 with ser_sof on the ID bit.
